// File: rtl/lzw_backward_reverse_rd_ctrl.sv
// lzw_backward_reverse_rd_ctrl: reorder-RAM read scheduler with EOF tagging and free-space credit; LZW_REV_RDCTRL_STAT_EN adds byte/frame counters
module lzw_backward_reverse_rd_ctrl #(
    parameter int RD_GAP    = 1,
    parameter int EOF_DEPTH = 4
) (
    input  logic        I_sys_clk,
    input  logic        I_sys_rst,
    input  logic        I_commit_en,
    input  logic [5:0]  I_commit_len,
    input  logic        I_commit_eof,
    input  logic        I_rd_enable,
    input  logic        I_state_clr,
    output logic        O_ram_rd_en,
    output logic [9:0]  O_ram_rd_addr,
    input  logic [7:0]  I_ram_rd_data,
    output logic [7:0]  O_payload_data,
    output logic        O_payload_data_en,
    output logic        O_payload_last,
`ifdef LZW_REV_RDCTRL_STAT_EN
    output logic [15:0] O_rd_byte_cnt,
    output logic [15:0] O_frame_cnt,
`endif
    output logic [10:0] O_free_space,
    output logic        O_err
);
    localparam int AW = (EOF_DEPTH > 1) ? $clog2(EOF_DEPTH) : 1;
    localparam int GW = (RD_GAP > 0) ? $clog2(RD_GAP + 1) : 1;
    localparam logic [AW:0] EOF_FULL = (AW + 1)'(EOF_DEPTH);
    localparam logic [GW-1:0] GAP_LOAD = GW'(RD_GAP);

    typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

    state_t        state_q, state_d;
    logic [10:0]   level_q, level_d, free_q, free_d;
    logic [9:0]    rd_ptr_q, rd_ptr_d, cmt_ptr_q, cmt_ptr_d, push_addr;
    logic [GW-1:0] gap_q, gap_d;
    logic [AW-1:0] eof_wr_q, eof_wr_d, eof_rd_q, eof_rd_d;
    logic [AW:0]   eof_cnt_q, eof_cnt_d;
    logic [9:0]    eof_mem_q [EOF_DEPTH];
    logic          err_q, err_d, v1_q, v1_d, last1_q, last1_d;
    logic          den_q, den_d, last_q, last_d;
    logic [7:0]    dat_q, dat_d;
    logic          commit_req, reject, accept, push, issue, is_last;

    always_comb begin
        commit_req = I_commit_en && I_commit_len != 6'd0;
        // Admission uses registered level and queue depth, so a same-cycle read or pop never rescues a commit
        reject     = commit_req && ((level_q + 11'(I_commit_len) > 11'd1024) ||
                                    (I_commit_eof && eof_cnt_q == EOF_FULL));
        accept     = commit_req && !reject;
        push       = accept && I_commit_eof;
        push_addr  = cmt_ptr_q + 10'(I_commit_len) - 10'd1;
        issue      = state_q == READ && level_q != 11'd0 && I_rd_enable && gap_q == '0;
        is_last    = issue && eof_cnt_q != '0 && rd_ptr_q == eof_mem_q[eof_rd_q];
        level_d    = level_q + (accept ? 11'(I_commit_len) : 11'd0) - (issue ? 11'd1 : 11'd0);
        free_d     = 11'd1024 - level_d;
        cmt_ptr_d  = accept ? cmt_ptr_q + 10'(I_commit_len) : cmt_ptr_q;
        rd_ptr_d   = issue ? rd_ptr_q + 10'd1 : rd_ptr_q;
        gap_d      = issue ? GAP_LOAD : (gap_q != '0 ? gap_q - GW'(1) : gap_q);
        eof_wr_d   = push ? eof_wr_q + AW'(1) : eof_wr_q;
        eof_rd_d   = is_last ? eof_rd_q + AW'(1) : eof_rd_q;
        eof_cnt_d  = eof_cnt_q + (push ? (AW + 1)'(1) : '0) - (is_last ? (AW + 1)'(1) : '0);
        err_d      = err_q || reject;
        v1_d       = issue;
        last1_d    = is_last;
        den_d      = v1_q;
        last_d     = v1_q && last1_q;
        dat_d      = v1_q ? I_ram_rd_data : dat_q;
        state_d    = state_q;
        case (state_q)
            IDLE:    state_d = (level_q != 11'd0 && I_rd_enable) ? READ : IDLE;
            READ:    state_d = !I_rd_enable ? HOLD : (level_q == 11'd0 ? IDLE : READ);
            HOLD:    state_d = (I_rd_enable && level_q != 11'd0) ? READ :
                               (level_q == 11'd0 ? IDLE : HOLD);
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_sys_rst) begin
            state_q   <= IDLE;
            level_q   <= '0;
            free_q    <= 11'd1024;
            rd_ptr_q  <= '0;
            cmt_ptr_q <= '0;
            gap_q     <= '0;
            eof_wr_q  <= '0;
            eof_rd_q  <= '0;
            eof_cnt_q <= '0;
            err_q     <= 1'b0;
            v1_q      <= 1'b0;
            last1_q   <= 1'b0;
            den_q     <= 1'b0;
            last_q    <= 1'b0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            free_q    <= free_d;
            rd_ptr_q  <= rd_ptr_d;
            cmt_ptr_q <= cmt_ptr_d;
            gap_q     <= gap_d;
            eof_wr_q  <= eof_wr_d;
            eof_rd_q  <= eof_rd_d;
            eof_cnt_q <= eof_cnt_d;
            err_q     <= err_d;
            v1_q      <= v1_d;
            last1_q   <= last1_d;
            den_q     <= den_d;
            last_q    <= last_d;
            dat_q     <= dat_d;
        end
    end

    always_ff @(posedge I_sys_clk) begin
        if (push) eof_mem_q[eof_wr_q] <= push_addr;
    end

    assign O_ram_rd_en       = issue;
    assign O_ram_rd_addr     = rd_ptr_q;
    assign O_payload_data    = dat_q;
    assign O_payload_data_en = den_q;
    assign O_payload_last    = last_q;
    assign O_free_space      = free_q;
    assign O_err             = err_q;

`ifdef LZW_REV_RDCTRL_STAT_EN
    logic        clr_q;
    logic [15:0] byte_cnt_q, byte_cnt_d, frame_cnt_q, frame_cnt_d;

    always_comb begin
        byte_cnt_d  = clr_q ? '0 : byte_cnt_q + (den_q ? 16'd1 : 16'd0);
        frame_cnt_d = clr_q ? '0 : frame_cnt_q + (last_q ? 16'd1 : 16'd0);
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_sys_rst) begin
            clr_q       <= 1'b0;
            byte_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            clr_q       <= I_state_clr;
            byte_cnt_q  <= byte_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign O_rd_byte_cnt = byte_cnt_q;
    assign O_frame_cnt   = frame_cnt_q;
`else
    logic unused_state_clr;
    assign unused_state_clr = I_state_clr;
`endif
endmodule

// File: tb/tb_lzw_backward_reverse_rd_ctrl.sv
// tb_lzw_backward_reverse_rd_ctrl: table, directed and random checks against a byte-queue model of the payload stream
module tb_lzw_backward_reverse_rd_ctrl;
    logic        clk = 1'b0, rst = 1'b1, commit_en = 1'b0, commit_eof = 1'b0;
    logic        rd_enable = 1'b0, state_clr = 1'b0;
    logic [5:0]  commit_len = '0;
    logic        ram_rd_en, data_en, last, err;
    logic [9:0]  ram_rd_addr;
    logic [7:0]  ram_q = '0, data;
    logic [10:0] free;
`ifdef LZW_REV_RDCTRL_STAT_EN
    logic [15:0] rd_byte_cnt, frame_cnt;
`endif

    lzw_backward_reverse_rd_ctrl dut (
        .I_sys_clk(clk),
        .I_sys_rst(rst),
        .I_commit_en(commit_en),
        .I_commit_len(commit_len),
        .I_commit_eof(commit_eof),
        .I_rd_enable(rd_enable),
        .I_state_clr(state_clr),
        .O_ram_rd_en(ram_rd_en),
        .O_ram_rd_addr(ram_rd_addr),
        .I_ram_rd_data(ram_q),
        .O_payload_data(data),
        .O_payload_data_en(data_en),
        .O_payload_last(last),
`ifdef LZW_REV_RDCTRL_STAT_EN
        .O_rd_byte_cnt(rd_byte_cnt),
        .O_frame_cnt(frame_cnt),
`endif
        .O_free_space(free),
        .O_err(err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [9:0] addr; logic last; } exp_t;
    typedef struct { int pre; int len; logic eof; logic exp_err; int exp_free; } vec_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] ram [1024];
    int         errors = 0, checks = 0, cyc = 0, rd_cnt = 0, dcnt = 0, first_rd = -1;
    logic       h1 = 1'b0, h2 = 1'b0;
    logic [9:0] exp_addr = '0, tb_cmt = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_rd_en) ram_q <= ram[ram_rd_addr];
    end

    function automatic void chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_commit(int len, logic eof);
        for (int i = 0; i < len; i++) begin
            exp_t e;
            e.addr = tb_cmt + 10'(i);
            e.last = eof && (i == len - 1);
            exp_q.push_back(e);
        end
        tb_cmt = tb_cmt + 10'(len);
    endtask

    task automatic commit(int len, logic eof, logic acc);
        commit_en = 1'b1;
        commit_len = 6'(len);
        commit_eof = eof;
        if (acc) model_commit(len, eof);
        tick();
        commit_en = 1'b0;
        commit_eof = 1'b0;
        commit_len = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        commit_en = 1'b0;
        commit_eof = 1'b0;
        commit_len = '0;
        rd_enable = 1'b0;
        state_clr = 1'b0;
        exp_q.delete();
        tb_cmt = '0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic fill(int n);
        while (n > 0) begin
            commit(n > 32 ? 32 : n, 1'b0, 1'b1);
            n -= 32;
        end
    endtask

    task automatic drain(string name, int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        repeat (4) tick();
        chk(name, exp_q.size(), 0);
    endtask

    function automatic int eof_pending();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i].last) n++;
        return n;
    endfunction

    task automatic chk_reset_vals(string tag);
        chk({tag, "_rd_en"}, int'(ram_rd_en), 0);
        chk({tag, "_rd_addr"}, int'(ram_rd_addr), 0);
        chk({tag, "_data"}, int'(data), 0);
        chk({tag, "_data_en"}, int'(data_en), 0);
        chk({tag, "_last"}, int'(last), 0);
        chk({tag, "_free"}, int'(free), 1024);
        chk({tag, "_err"}, int'(err), 0);
    endtask

    initial forever begin
        @(negedge clk);
        if (rst) begin
            h1 = 1'b0;
            h2 = 1'b0;
            exp_addr = '0;
            rd_cnt = 0;
            dcnt = 0;
            first_rd = -1;
        end else begin
            if (data_en || h2) chk("data_en_latency", int'(data_en), int'(h2));
            if (ram_rd_en) begin
                chk("rd_addr", int'(ram_rd_addr), int'(exp_addr));
                chk("rd_gap", int'(h1), 0);
                if (first_rd < 0) first_rd = cyc;
                exp_addr = exp_addr + 10'd1;
                rd_cnt++;
            end
            if (data_en) begin
                dcnt++;
                chk("data_en_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("payload_data", int'(data), int'(ram[mon_e.addr]));
                    chk("payload_last", int'(last), int'(mon_e.last));
                end
            end
            h2 = h1;
            h1 = ram_rd_en;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        int   c0, d0, r0, len;
        logic eof;
        tbl[0] = '{0, 5, 1'b1, 1'b0, 1019};
        tbl[1] = '{1000, 32, 1'b0, 1'b1, 24};
        tbl[2] = '{992, 32, 1'b0, 1'b0, 0};
        tbl[3] = '{1000, 24, 1'b1, 1'b0, 0};
        tbl[4] = '{0, 0, 1'b1, 1'b0, 1024};
        tbl[5] = '{1020, 5, 1'b0, 1'b1, 4};
        for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);

        do_reset();
        chk_reset_vals("rst");

        foreach (tbl[i]) begin
            do_reset();
            fill(tbl[i].pre);
            commit(tbl[i].len, tbl[i].eof, !tbl[i].exp_err && tbl[i].len != 0);
            chk("tbl_err", int'(err), int'(tbl[i].exp_err));
            chk("tbl_free", int'(free), tbl[i].exp_free);
        end

        do_reset();
        rd_enable = 1'b1;
        c0 = cyc;
        commit(5, 1'b1, 1'b1);
        chk("p1_free_after_commit", int'(free), 1019);
        drain("p1_drain", 100);
        chk("p1_first_rd_lat", first_rd - c0, 2);
        chk("p1_reads", rd_cnt, 5);
        chk("p1_free", int'(free), 1024);
        chk("p1_err", int'(err), 0);

        do_reset();
        rd_enable = 1'b1;
        fill(1020);
        for (int i = 0; i < 5000 && !(exp_addr == 10'd1020 && exp_q.size() == 0); i++) tick();
        chk("wrap_ptr", int'(exp_addr), 1020);
        commit(8, 1'b1, 1'b1);
        drain("wrap_drain", 100);
        chk("wrap_addr_after", int'(exp_addr), 4);
        chk("wrap_err", int'(err), 0);
        chk("wrap_free", int'(free), 1024);

        do_reset();
        commit(3, 1'b0, 1'b1);
        rd_enable = 1'b1;
        tick();
        commit_en = 1'b1;
        commit_len = 6'd4;
        model_commit(4, 1'b0);
        @(negedge clk);
        chk("same_cyc_rd", int'(ram_rd_en), 1);
        tick();
        commit_en = 1'b0;
        commit_len = '0;
        chk("same_cyc_free", int'(free), 1018);
        drain("same_cyc_drain", 100);

        do_reset();
        rd_enable = 1'b1;
        commit(20, 1'b0, 1'b1);
        repeat (10) tick();
        rd_enable = 1'b0;
        d0 = dcnt;
        r0 = rd_cnt;
        repeat (10) tick();
        chk("drop_tail_le2", int'(dcnt - d0 <= 2), 1);
        chk("drop_no_rd", rd_cnt - r0, 0);
        chk("drop_pending", int'(exp_q.size() > 0), 1);
        rd_enable = 1'b1;
        drain("drop_drain", 200);
        chk("drop_free", int'(free), 1024);

        do_reset();
        for (int i = 0; i < 4; i++) commit(1, 1'b1, 1'b1);
        commit(1, 1'b1, 1'b0);
        chk("eofq_err", int'(err), 1);
        chk("eofq_free", int'(free), 1020);
        rd_enable = 1'b1;
        repeat (2) tick();
        do_reset();
        chk_reset_vals("rst2");
        rd_enable = 1'b1;
        repeat (10) tick();
        chk("rst2_no_rd", rd_cnt, 0);
        chk("rst2_no_data", dcnt, 0);

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rd_enable = ($urandom_range(0, 3) != 0);
            len = $urandom_range(0, 32);
            if ($urandom_range(0, 3) == 0 && exp_q.size() + len <= 1024) begin
                eof = (eof_pending() < 4) && ($urandom_range(0, 2) == 0);
                commit(len, eof, 1'b1);
            end else begin
                tick();
            end
        end
        rd_enable = 1'b1;
        drain("rand_drain", 4000);
        chk("rand_err", int'(err), 0);
        chk("rand_free", int'(free), 1024);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
